// File: rtl/alu_seq_mc_if.sv
// Request/result handshake bundle for alu_seq_mc.
// master issues operations and out_ready; slave (the ALU) returns in_ready and results.
interface alu_seq_mc_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ALUOp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
    logic             ZERO;

    modport master (
        output in_valid, a, b, ALUOp, out_ready,
        input  in_ready, out_valid, Result, ZERO
    );

    modport slave (
        input  in_valid, a, b, ALUOp, out_ready,
        output in_ready, out_valid, Result, ZERO
    );
endinterface

// File: rtl/alu_seq_mc.sv
// Multi-cycle ALU: logic/arith/shift/SLT single-cycle, iterative MUL; unsigned DIVU only with ALU_SEQ_DIV_EN.
// Latency: 1 clock single-cycle ops, WIDTH clocks MUL/DIVU (accept edge counted as the first clock).
// Backpressure: in_ready only in IDLE; Result/ZERO held in DONE until out_ready.
module alu_seq_mc #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        reset_n,
    alu_seq_mc_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0]   count;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic             is_iter;
    logic [WIDTH-1:0] ld_acc;
    logic [WIDTH-1:0] ld_mcand;
    logic [WIDTH-1:0] ld_mplier;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] mcand_nx;
    logic [WIDTH-1:0] mplier_nx;
    logic [WIDTH-1:0] busy_res;
    logic             last_iter;

`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OP_DIVU = 4'b1001;

    logic ld_div;
    logic div_mode;

    // One restoring step: acc holds the partial remainder, mplier the dividend
    // shifting out MSB-first while quotient bits shift in at the bottom.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] rem,
        input logic [WIDTH-1:0] quo,
        input logic [WIDTH-1:0] dvs
    );
        logic [WIDTH:0] sh_rem;
        logic [WIDTH:0] diff;
        sh_rem = {rem, quo[WIDTH-1]};
        diff   = sh_rem - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            div_step = {diff[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
        end else begin
            div_step = {sh_rem[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
        end
    endfunction
`endif

    assign bus.in_ready = (state == IDLE);
    assign shamt        = bus.b[SHW-1:0];
    assign last_iter    = (count == SHW'(WIDTH - 1));

    // Opcode decode. Iterative ops also prepare their first iteration here,
    // which is folded into the accept edge so that they finish in WIDTH clocks.
    always_comb begin
        sc_res    = '0;
        is_iter   = 1'b0;
        ld_acc    = bus.b[0] ? bus.a : '0;
        ld_mcand  = bus.a << 1;
        ld_mplier = bus.b >> 1;
`ifdef ALU_SEQ_DIV_EN
        ld_div    = 1'b0;
`endif
        case (bus.ALUOp)
            OP_AND: sc_res = bus.a & bus.b;
            OP_OR:  sc_res = bus.a | bus.b;
            OP_ADD: sc_res = bus.a + bus.b;
            OP_SUB: sc_res = bus.a - bus.b;
            OP_NOR: sc_res = ~(bus.a | bus.b);
            OP_SLL: sc_res = bus.a << shamt;
            OP_SRL: sc_res = bus.a >> shamt;
            OP_SRA: sc_res = $unsigned($signed(bus.a) >>> shamt);
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_MUL: is_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: begin
                is_iter  = 1'b1;
                ld_div   = 1'b1;
                {ld_acc, ld_mplier} = div_step('0, bus.a, bus.b);
                ld_mcand = bus.b;
            end
`endif
            default: sc_res = '0;
        endcase
    end

    // Next iteration of the running multi-cycle operation.
    always_comb begin
        acc_nx    = acc + (mplier[0] ? mcand : '0);
        mcand_nx  = mcand << 1;
        mplier_nx = mplier >> 1;
        busy_res  = acc_nx;
`ifdef ALU_SEQ_DIV_EN
        if (div_mode) begin
            {acc_nx, mplier_nx} = div_step(acc, mplier, mcand);
            mcand_nx = mcand;
            busy_res = mplier_nx;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            count         <= '0;
            bus.Result    <= '0;
            bus.ZERO      <= 1'b0;
            bus.out_valid <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
            div_mode      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_iter) begin
                            acc    <= ld_acc;
                            mcand  <= ld_mcand;
                            mplier <= ld_mplier;
                            count  <= SHW'(1);
                            state  <= BUSY;
`ifdef ALU_SEQ_DIV_EN
                            div_mode <= ld_div;
`endif
                        end else begin
                            bus.Result    <= sc_res;
                            bus.ZERO      <= (sc_res == '0);
                            bus.out_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc    <= acc_nx;
                    mcand  <= mcand_nx;
                    mplier <= mplier_nx;
                    count  <= count + 1'b1;
                    if (last_iter) begin
                        bus.Result    <= busy_res;
                        bus.ZERO      <= (busy_res == '0);
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_mc.sv
// Directed bench for alu_seq_mc (WIDTH=64): hand-computed vectors plus a cycle-level reference model.
// Define ALU_SEQ_DIV_EN for both bench and RTL to exercise the divider.
module tb_alu_seq_mc;
    localparam int W = 64;
    localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SLL = 4'b0011;
    localparam logic [3:0] OP_SRL = 4'b0100, OP_SRA = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000, OP_DIVU = 4'b1001, OP_NOR = 4'b1100, OP_BAD = 4'b1111;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_seq_mc_if #(.WIDTH(W)) bus ();

    alu_seq_mc #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: what each opcode must return, straight from the arithmetic definition.
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [5:0] sh;
        sh = b[5:0];
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $unsigned($signed(a) >>> sh);
            OP_SLT:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            OP_MUL:  return a * b;
`ifdef ALU_SEQ_DIV_EN
            OP_DIVU: return (b == 0) ? ONES : a / b;
`endif
            default: return '0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
        if (op == OP_DIVU) return W;
`endif
        return (op == OP_MUL) ? W : 1;
    endfunction

    // Model: 0 = ready for work, 1 = computing, 2 = result offered.
    int         m_phase = 0;
    int         m_left  = 0;
    logic [W-1:0] m_pend = '0;
    logic [W-1:0] m_res  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_res   <= '0;
        end else begin
            case (m_phase)
                0: if (bus.in_valid === 1'b1) begin
                    if (ref_latency(bus.ALUOp) == 1) begin
                        m_res   <= ref_result(bus.ALUOp, bus.a, bus.b);
                        m_phase <= 2;
                    end else begin
                        m_pend  <= ref_result(bus.ALUOp, bus.a, bus.b);
                        m_left  <= ref_latency(bus.ALUOp) - 1;
                        m_phase <= 1;
                    end
                end
                1: if (m_left == 1) begin
                    m_res   <= m_pend;
                    m_phase <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (bus.out_ready === 1'b1) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("model_in_ready", bus.in_ready, m_phase == 0);
        chk("model_out_valid", bus.out_valid, m_phase == 2);
        if (m_phase == 2) begin
            chk("model_result", bus.Result, m_res);
            chk("model_zero", bus.ZERO, m_res == 0);
        end
    end

    task automatic start(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic rdy);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.ALUOp     = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = rdy;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.ALUOp    = OP_BAD;
        bus.a        = ONES;
        bus.b        = ONES;
    endtask

    // Counts clocks from the accept edge (inclusive) until out_valid; pokes a
    // request mid-operation which must not be taken.
    task automatic wait_valid(output int n);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 200) begin
            if (n == 5) begin
                bus.in_valid = 1'b1;
                bus.ALUOp    = OP_ADD;
                bus.a        = 64'd1;
                bus.b        = 64'd2;
            end
            if (n == 10) bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic do_op(input string nm, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp, input int exp_lat);
        int n;
        start(op, a, b, 1'b1);
        wait_valid(n);
        chk({nm, "_latency"}, n, exp_lat);
        chk({nm, "_result"}, bus.Result, exp);
        chk({nm, "_zero"}, bus.ZERO, exp == 0);
        @(posedge clk);
        #1;
        chk({nm, "_in_ready_after"}, bus.in_ready, 1'b1);
        chk({nm, "_out_valid_after"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ALUOp     = OP_AND;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_result", bus.Result, '0);
        chk("reset_zero", bus.ZERO, 1'b0);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        do_op("add_5_7",   OP_ADD, 64'd5, 64'd7, 64'd12, 1);
        do_op("sub_9_9",   OP_SUB, 64'd9, 64'd9, 64'd0, 1);
        do_op("sra_msb_4", OP_SRA, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000, 1);
        do_op("slt_m1_1",  OP_SLT, ONES, 64'd1, 64'd1, 1);
        do_op("slt_1_m1",  OP_SLT, 64'd1, ONES, 64'd0, 1);
        do_op("nor_0_0",   OP_NOR, 64'd0, 64'd0, ONES, 1);
        do_op("op_1111",   OP_BAD, 64'd5, 64'd7, 64'd0, 1);
        do_op("and",       OP_AND, 64'hF0F0, 64'hFF00, 64'hF000, 1);
        do_op("or",        OP_OR,  64'hF0F0, 64'hFF00, 64'hFFF0, 1);
        do_op("sll_hi_b",  OP_SLL, 64'd1, 64'h104, 64'h10, 1);
        do_op("srl_63",    OP_SRL, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1);
        do_op("add_wrap",  OP_ADD, ONES, 64'd1, 64'd0, 1);
        do_op("mul_big",   OP_MUL, 64'hFFFF_FFFF, 64'h1_0000_0001, ONES, 64);
        do_op("mul_neg",   OP_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1, 64);
        do_op("mul_zero",  OP_MUL, 64'd0, 64'h1234_5678, 64'd0, 64);
`ifdef ALU_SEQ_DIV_EN
        do_op("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 64);
        do_op("divu_by_0",  OP_DIVU, 64'd55, 64'd0, ONES, 64);
`else
        do_op("divu_off",   OP_DIVU, 64'd100, 64'd7, 64'd0, 1);
`endif

        // Result held under backpressure
        start(OP_MUL, 64'd3, 64'd7, 1'b0);
        wait_valid(n);
        chk("bp_latency", n, 64);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid_hold", bus.out_valid, 1'b1);
            chk("bp_result_hold", bus.Result, 64'd21);
            chk("bp_in_ready_low", bus.in_ready, 1'b0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", bus.in_ready, 1'b1);
        chk("bp_release_out_valid", bus.out_valid, 1'b0);

        // Reset during the 20th multiply iteration
        start(OP_MUL, 64'h1234, 64'h5678, 1'b1);
        repeat (19) @(posedge clk);
        #1;
        chk("abort_busy_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", bus.out_valid, 1'b0);
        chk("abort_in_ready", bus.in_ready, 1'b1);
        chk("abort_result", bus.Result, 64'd0);
        chk("abort_zero", bus.ZERO, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("add_after_abort", OP_ADD, 64'd1, 64'd1, 64'd2, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
